// File: rtl/random_delay_display_pkg.sv
// Shared definitions for the random reaction-delay display block.
// Holds the controller state encoding and the active-low 7-segment patterns,
// ordered {g,f,e,d,c,b,a}.
package random_delay_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SHOW = 2'd2,
        ST_DONE = 2'd3
    } rdd_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/random_delay_display_seg7.sv
// One BCD digit to active-low 7-segment pattern.
// Ports: i_bcd   - 4-bit BCD code (10..15 decode to blank)
//        i_blank - force the digit dark (leading-zero suppression)
//        o_seg_c - combinational {g,f,e,d,c,b,a}, active-low
module random_delay_display_seg7
    import random_delay_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg_c = SEG_0;
                4'd1:    o_seg_c = SEG_1;
                4'd2:    o_seg_c = SEG_2;
                4'd3:    o_seg_c = SEG_3;
                4'd4:    o_seg_c = SEG_4;
                4'd5:    o_seg_c = SEG_5;
                4'd6:    o_seg_c = SEG_6;
                4'd7:    o_seg_c = SEG_7;
                4'd8:    o_seg_c = SEG_8;
                4'd9:    o_seg_c = SEG_9;
                default: o_seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/random_delay_display.sv
// Random reaction-test delay generator with 7-segment readout.
// A free-running Galois LFSR supplies a random offset on start; the value is
// converted to BCD by a sequential double-dabble and shown on active-low digits,
// optionally counting down on tick until it expires at zero.
// Ports: clk, rst (async, active-high)
//        start     - capture random value and begin conversion
//        tick      - count-down strobe
//        seed_load - load LFSR from seed (zero seed maps to 1)
//        seed      - LFSR seed
//        busy      - conversion in progress
//        expired   - sticky, count reached zero
//        value     - current binary delay value
//        seg_out   - {digit N-1 .. digit 0}, each {g,f,e,d,c,b,a}, active-low
module random_delay_display
    import random_delay_display_pkg::*;
#(
    parameter int unsigned       LFSR_W     = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'h5A,
    parameter int unsigned       RAND_BITS  = 4,
    parameter int unsigned       MIN_VAL    = 20,
    parameter int unsigned       VAL_W      = 6,
    parameter int unsigned       NUM_DIGITS = 2,
    parameter bit                COUNT_DOWN = 1'b1,
    parameter bit                BLANK_LZ   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    tick,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed,
    output logic                    busy,
    output logic                    expired,
    output logic [VAL_W-1:0]        value,
    output logic [7*NUM_DIGITS-1:0] seg_out
);

    localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W   = $clog2(VAL_W + 1);
    localparam int unsigned MAX_VAL = MIN_VAL + (32'd1 << RAND_BITS) - 32'd1;
    localparam int unsigned BIN_LIM = 32'd1 << VAL_W;
    localparam int unsigned DEC_LIM = 10 ** NUM_DIGITS;

    // Largest loadable value must fit both the binary register and the digits.
    if (MAX_VAL >= BIN_LIM || MAX_VAL >= DEC_LIM || RAND_BITS > LFSR_W || RAND_BITS == 0)
    begin : g_bad_params
        $error("random_delay_display: parameter set cannot hold MIN_VAL + max offset");
    end

    rdd_state_t              r_state;
    rdd_state_t              w_state_next;
    logic [LFSR_W-1:0]       r_lfsr;
    logic [VAL_W-1:0]        r_value;
    logic [VAL_W-1:0]        r_bin;
    logic [BCD_W-1:0]        r_bcd;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;
    logic                    r_expired;
    logic                    r_pending;
    logic [7*NUM_DIGITS-1:0] r_seg;

    logic                    w_load;
    logic                    w_dec;
    logic                    w_shift;
    logic                    w_last;
    logic                    w_tick_en;
    logic [LFSR_W-1:0]       w_lfsr_next;
    logic [VAL_W-1:0]        w_rand_val;
    logic [VAL_W-1:0]        w_value_next;
    logic [BCD_W-1:0]        w_bcd_adj;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_zero_hi;
    logic [7*NUM_DIGITS-1:0] w_seg_dec;

    assign w_tick_en    = tick & COUNT_DOWN;
    assign w_lfsr_next  = seed_load ? ((seed == '0) ? LFSR_W'(1) : seed)
                                    : ({1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0));
    assign w_rand_val   = VAL_W'(MIN_VAL) + VAL_W'(r_lfsr[RAND_BITS-1:0]);
    assign w_value_next = w_load ? w_rand_val : (r_value - VAL_W'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_next = ST_CONV;
            ST_SHOW:          if (start || w_tick_en) w_state_next = ST_CONV;
            ST_CONV: begin
                if (w_last) begin
                    if (w_dec)                w_state_next = ST_CONV;
                    else if (r_value == '0)   w_state_next = ST_DONE;
                    else                      w_state_next = ST_SHOW;
                end
            end
            default:          w_state_next = ST_IDLE;
        endcase
    end

    // Control decode; a tick on the final conversion cycle counts as pending
    always_comb begin
        w_load  = 1'b0;
        w_dec   = 1'b0;
        w_shift = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: w_load = start;
            ST_SHOW: begin
                w_load = start;
                w_dec  = !start && w_tick_en;
            end
            ST_CONV: begin
                if (r_cnt == CNT_W'(VAL_W)) begin
                    w_last = 1'b1;
                    w_dec  = (r_pending || w_tick_en) && (r_value != '0);
                end else begin
                    w_shift = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Double-dabble add-3 correction per BCD digit
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking; the ones digit is never blanked
    always_comb begin
        w_blank   = '0;
        w_zero_hi = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            w_zero_hi  = w_zero_hi && (r_bcd[4*k +: 4] == 4'd0);
            w_blank[k] = BLANK_LZ && w_zero_hi;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        random_delay_display_seg7 u_seg7 (
            .i_bcd   (r_bcd[4*g +: 4]),
            .i_blank (w_blank[g]),
            .o_seg_c (w_seg_dec[7*g +: 7])
        );
    end

    // Datapath: LFSR, value, shifter, flags and display registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr    <= LFSR_SEED;
            r_value   <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
            r_pending <= 1'b0;
            r_seg     <= '1;
        end else begin
            r_lfsr <= w_lfsr_next;

            if (w_load || w_dec) begin
                r_value <= w_value_next;
                r_bin   <= w_value_next;
                r_bcd   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else if (w_shift) begin
                r_bcd <= BCD_W'({w_bcd_adj, r_bin[VAL_W-1]});
                r_bin <= {r_bin[VAL_W-2:0], 1'b0};
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_last) begin
                r_seg <= w_seg_dec;
                if (!w_dec) r_busy <= 1'b0;
            end

            if (w_load) begin
                r_expired <= 1'b0;
            end else if (w_last && !w_dec && r_value == '0) begin
                r_expired <= 1'b1;
            end

            if (w_load || w_last) begin
                r_pending <= 1'b0;
            end else if (r_state == ST_CONV && w_tick_en) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign busy    = r_busy;
    assign expired = r_expired;
    assign value   = r_value;
    assign seg_out = r_seg;

endmodule
